// File: rtl/picocode_loader.sv
// picocode_loader
//   Streams a framed program image from a byte source into the 1K x 18
//   picocode instruction RAM and holds the CPU in reset until an image
//   has been received intact.
//
//   Frame: A5 | CNT_HI | CNT_LO | N x (B0 B1 B2) | CKSUM
//     CNT = N-1 (10 bits), word = {B0[1:0], B1, B2}, CKSUM = mod-256 sum
//     of every byte between SYNC and CKSUM.
//
// Ports
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   rx_data/valid     incoming byte stream
//   rx_ready          byte accepted when rx_valid && rx_ready at a clk edge
//   ram_data          18-bit instruction word to the RAM
//   ram_address       10-bit RAM word address
//   ram_enable        RAM enable, high only on write cycles
//   ram_wr_en         RAM write enable (same as ram_enable)
//   cpu_reset         active-high CPU hold
//   load_busy         a frame is in progress
//   load_done         one-cycle pulse: image accepted
//   load_error        one-cycle pulse: frame aborted
//   err_code          last error: 01 format, 10 checksum, 11 timeout
module picocode_loader #(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [17:0] ram_data,
  output logic [9:0]  ram_address,
  output logic        ram_enable,
  output logic        ram_wr_en,
  output logic        cpu_reset,
  output logic        load_busy,
  output logic        load_done,
  output logic        load_error,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_HI,
    S_CNT_LO,
    S_B0,
    S_B1,
    S_B2,
    S_WRITE,
    S_CKSUM
  } state_t;

  localparam logic [7:0]  SYNC_BYTE = 8'hA5;
  localparam logic [1:0]  ERR_FMT   = 2'b01;
  localparam logic [1:0]  ERR_CKSUM = 2'b10;
  localparam logic [1:0]  ERR_TMO   = 2'b11;
  localparam logic [23:0] TMO_LAST  = 24'(TIMEOUT_CYCLES - 1);

  function automatic logic [7:0] cksum_add(input logic [7:0] sum_in,
                                           input logic [7:0] byte_in);
    return sum_in + byte_in;
  endfunction

  state_t      state;
  state_t      state_nxt;
  logic        ready_en;
  logic        accept;
  logic        sync_hit;
  logic        tmo_hit;
  logic        last_word;
  logic        done_nxt;
  logic        error_nxt;
  logic [1:0]  code_nxt;
  logic [23:0] idle_cnt;
  logic [9:0]  word_idx;
  logic [9:0]  cnt_m1;
  logic [7:0]  sum;
  logic [1:0]  b0_hi;
  logic [7:0]  b1;

  // ready_en keeps rx_ready low while reset is asserted and for the
  // first edge after release; WRITE is the per-word bubble
  assign rx_ready    = ready_en && (state != S_WRITE);
  assign ram_enable  = (state == S_WRITE);
  assign ram_wr_en   = ram_enable;
  assign load_busy   = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    error_nxt = 1'b0;
    code_nxt  = err_code;
    sync_hit  = 1'b0;
    accept    = rx_valid && rx_ready;
    last_word = (word_idx == cnt_m1);
    // a byte arriving on the expiry edge wins over the timeout
    tmo_hit   = (state != S_IDLE) && !accept && (idle_cnt == TMO_LAST);

    case (state)
      S_IDLE: begin
        if (accept && rx_data == SYNC_BYTE) begin
          state_nxt = S_CNT_HI;
          sync_hit  = 1'b1;
        end
      end
      S_CNT_HI: begin
        if (accept) begin
          if (rx_data[7:2] != 6'd0) begin
            state_nxt = S_IDLE;
            error_nxt = 1'b1;
            code_nxt  = ERR_FMT;
          end else begin
            state_nxt = S_CNT_LO;
          end
        end
      end
      S_CNT_LO: if (accept) state_nxt = S_B0;
      S_B0: begin
        if (accept) begin
          if (rx_data[7:2] != 6'd0) begin
            state_nxt = S_IDLE;
            error_nxt = 1'b1;
            code_nxt  = ERR_FMT;
          end else begin
            state_nxt = S_B1;
          end
        end
      end
      S_B1:    if (accept) state_nxt = S_B2;
      S_B2:    if (accept) state_nxt = S_WRITE;
      S_WRITE: state_nxt = last_word ? S_CKSUM : S_B0;
      S_CKSUM: begin
        if (accept) begin
          state_nxt = S_IDLE;
          if (rx_data == sum) begin
            done_nxt = 1'b1;
          end else begin
            error_nxt = 1'b1;
            code_nxt  = ERR_CKSUM;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase

    if (tmo_hit) begin
      state_nxt = S_IDLE;
      error_nxt = 1'b1;
      code_nxt  = ERR_TMO;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      ready_en    <= 1'b0;
      idle_cnt    <= '0;
      cpu_reset   <= 1'b0;
      load_done   <= 1'b0;
      load_error  <= 1'b0;
      err_code    <= 2'b00;
      ram_data    <= '0;
      ram_address <= '0;
    end else begin
      state      <= state_nxt;
      ready_en   <= 1'b1;
      load_done  <= done_nxt;
      load_error <= error_nxt;
      err_code   <= code_nxt;

      if (state == S_IDLE || accept || tmo_hit) begin
        idle_cnt <= '0;
      end else begin
        idle_cnt <= idle_cnt + 24'd1;
      end

      if (sync_hit) begin
        cpu_reset <= 1'b1;
      end else if (done_nxt) begin
        cpu_reset <= 1'b0;
      end

      // word assembly: B2 completes the word, presented in WRITE
      if (accept && state == S_B2) begin
        ram_data    <= {b0_hi, b1, rx_data};
        ram_address <= word_idx;
      end
    end
  end

  // byte capture and running checksum
  always_ff @(posedge clk) begin
    if (sync_hit) begin
      sum      <= '0;
      word_idx <= '0;
    end else begin
      if (accept && (state == S_CNT_HI || state == S_CNT_LO ||
                     state == S_B0 || state == S_B1 || state == S_B2)) begin
        sum <= cksum_add(sum, rx_data);
      end
      if (state == S_WRITE) begin
        word_idx <= word_idx + 10'd1;
      end
    end
    if (accept && state == S_CNT_HI) cnt_m1[9:8] <= rx_data[1:0];
    if (accept && state == S_CNT_LO) cnt_m1[7:0] <= rx_data;
    if (accept && state == S_B0)     b0_hi       <= rx_data[1:0];
    if (accept && state == S_B1)     b1          <= rx_data;
  end

endmodule

// File: tb/tb_picocode_loader.sv
// tb_picocode_loader
//   Directed bench for picocode_loader with TIMEOUT_CYCLES = 16.
module tb_picocode_loader;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [17:0] ram_data;
  logic [9:0]  ram_address;
  logic        ram_enable;
  logic        ram_wr_en;
  logic        cpu_reset;
  logic        load_busy;
  logic        load_done;
  logic        load_error;
  logic [1:0]  err_code;

  picocode_loader #(.TIMEOUT_CYCLES(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .rx_ready    (rx_ready),
    .ram_data    (ram_data),
    .ram_address (ram_address),
    .ram_enable  (ram_enable),
    .ram_wr_en   (ram_wr_en),
    .cpu_reset   (cpu_reset),
    .load_busy   (load_busy),
    .load_done   (load_done),
    .load_error  (load_error),
    .err_code    (err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int cyc    = 0;

  logic [17:0] ram_model [1024];
  logic [17:0] exp_word  [1024];
  int wr_cnt = 0, wr_cyc = 0, done_cnt = 0, done_cyc = 0;
  int err_cnt = 0, err_cyc = 0, en_mis = 0, drop_cnt = 0, busy_pulse = 0;
  logic [9:0] wr_addr = '0;
  int last_acc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ram_wr_en) begin
      ram_model[ram_address] = ram_data;
      wr_cnt++;
      wr_addr = ram_address;
      wr_cyc  = cyc;
    end
    if (ram_enable !== ram_wr_en) en_mis++;
    if (load_done) begin
      done_cnt++;
      done_cyc = cyc;
      if (load_busy) busy_pulse++;
    end
    if (load_error) begin
      err_cnt++;
      err_cyc = cyc;
      if (load_busy) busy_pulse++;
    end
    if (load_busy && !cpu_reset) drop_cnt++;
  end

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    if (gap > 0) begin
      rx_valid = 1'b0;
      tick(gap);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waited   = 0;
    while (!rx_ready && waited < 50) begin
      tick(1);
      waited++;
    end
    if (!rx_ready) begin
      check_eq("accept_wait", {31'd0, rx_ready}, 32'd1);
      rx_valid = 1'b0;
    end else begin
      tick(1);
      last_acc = cyc;
    end
  endtask

  task automatic send_frame(input logic [7:0] f [$], input int gap);
    foreach (f[i]) send_byte(f[i], (i == 0) ? 0 : gap);
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] fr [$];
    logic [7:0] sum;
    int w0, d0, e0, nbad, acc_b2;

    foreach (ram_model[i]) ram_model[i] = '0;
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick(3);

    // reset values
    check_eq("rst_rx_ready",   {31'd0, rx_ready},   32'd0);
    check_eq("rst_cpu_reset",  {31'd0, cpu_reset},  32'd0);
    check_eq("rst_busy",       {31'd0, load_busy},  32'd0);
    check_eq("rst_ram_en",     {31'd0, ram_enable}, 32'd0);
    check_eq("rst_err_code",   {30'd0, err_code},   32'd0);
    check_eq("rst_ram_data",   {14'd0, ram_data},   32'd0);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check_eq("rx_ready_after_rst", {31'd0, rx_ready}, 32'd1);

    // 2-word load
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45};
    send_frame(fr, 0);
    rx_valid = 1'b1;
    send_byte(8'h03, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    acc_b2 = last_acc;
    check_eq("t1_cpu_reset_mid", {31'd0, cpu_reset}, 32'd1);
    send_byte(8'h6B, 0);
    rx_valid = 1'b0;
    tick(3);
    check_eq("t1_writes",     wr_cnt - w0, 32'd2);
    check_eq("t1_word0",      {14'd0, ram_model[0]}, 32'h12345);
    check_eq("t1_word1",      {14'd0, ram_model[1]}, 32'h3FFFF);
    check_eq("t1_wr_timing",  wr_cyc, acc_b2);
    check_eq("t1_done",       done_cnt - d0, 32'd1);
    check_eq("t1_done_cycle", done_cyc, last_acc);
    check_eq("t1_no_error",   err_cnt - e0, 32'd0);
    check_eq("t1_cpu_reset",  {31'd0, cpu_reset}, 32'd0);

    // checksum error, then correct resend
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h01, 8'h01, 8'h23, 8'h45, 8'h03, 8'hFF, 8'hFF, 8'h6C};
    send_frame(fr, 0);
    tick(3);
    check_eq("t2_writes",     wr_cnt - w0, 32'd2);
    check_eq("t2_error",      err_cnt - e0, 32'd1);
    check_eq("t2_err_code",   {30'd0, err_code}, 32'd2);
    check_eq("t2_cpu_reset",  {31'd0, cpu_reset}, 32'd1);
    check_eq("t2_no_done",    done_cnt - d0, 32'd0);
    fr[9] = 8'h6B;
    send_frame(fr, 0);
    tick(3);
    check_eq("t2_resend_done", done_cnt - d0, 32'd1);
    check_eq("t2_resend_cpu",  {31'd0, cpu_reset}, 32'd0);
    check_eq("t2_code_held",   {30'd0, err_code}, 32'd2);

    // leading garbage
    w0 = wr_cnt; d0 = done_cnt;
    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h00, 8'h07, 8'h07};
    send_frame(fr, 0);
    tick(3);
    check_eq("t3_writes", wr_cnt - w0, 32'd1);
    check_eq("t3_word0",  {14'd0, ram_model[0]}, 32'h00007);
    check_eq("t3_addr",   {22'd0, wr_addr}, 32'd0);
    check_eq("t3_done",   done_cnt - d0, 32'd1);

    // format error in B0
    w0 = wr_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h00, 8'h04};
    send_frame(fr, 0);
    tick(3);
    check_eq("t4_error",     err_cnt - e0, 32'd1);
    check_eq("t4_err_cycle", err_cyc, last_acc);
    check_eq("t4_err_code",  {30'd0, err_code}, 32'd1);
    check_eq("t4_no_write",  wr_cnt - w0, 32'd0);

    // timeout after silence
    e0 = err_cnt;
    fr = '{8'hA5, 8'h00};
    send_frame(fr, 0);
    tick(20);
    check_eq("t5_error",      err_cnt - e0, 32'd1);
    check_eq("t5_tmo_cycles", err_cyc - last_acc, 32'd16);
    check_eq("t5_err_code",   {30'd0, err_code}, 32'd3);
    check_eq("t5_busy",       {31'd0, load_busy}, 32'd0);

    // 15-cycle gaps must not time out
    d0 = done_cnt; e0 = err_cnt;
    fr = '{8'hA5, 8'h00, 8'h00, 8'h03, 8'h12, 8'h34, 8'h49};
    send_frame(fr, 15);
    tick(3);
    check_eq("t6_done",     done_cnt - d0, 32'd1);
    check_eq("t6_no_error", err_cnt - e0, 32'd0);
    check_eq("t6_word0",    {14'd0, ram_model[0]}, 32'h31234);

    // full 1024-word load with random gaps
    w0 = wr_cnt; d0 = done_cnt; e0 = err_cnt;
    sum = 8'h03 + 8'hFF;
    send_byte(8'hA5, 0);
    send_byte(8'h03, $urandom_range(0, 6));
    send_byte(8'hFF, $urandom_range(0, 6));
    for (int k = 0; k < 1024; k++) begin
      exp_word[k] = 18'($urandom);
      send_byte({6'd0, exp_word[k][17:16]}, $urandom_range(0, 6));
      send_byte(exp_word[k][15:8], $urandom_range(0, 6));
      send_byte(exp_word[k][7:0],  $urandom_range(0, 6));
      sum = sum + {6'd0, exp_word[k][17:16]} + exp_word[k][15:8] + exp_word[k][7:0];
    end
    send_byte(sum, $urandom_range(0, 6));
    rx_valid = 1'b0;
    tick(3);
    nbad = 0;
    for (int k = 0; k < 1024; k++) if (ram_model[k] !== exp_word[k]) nbad++;
    check_eq("t7_bad_words", nbad, 32'd0);
    check_eq("t7_writes",    wr_cnt - w0, 32'd1024);
    check_eq("t7_last_addr", {22'd0, wr_addr}, 32'h3FF);
    check_eq("t7_done",      done_cnt - d0, 32'd1);
    check_eq("t7_no_error",  err_cnt - e0, 32'd0);

    // reset mid-word
    fr = '{8'hA5, 8'h00, 8'h01, 8'h00, 8'h11, 8'h22, 8'h01};
    send_frame(fr, 0);
    check_eq("t8_cpu_reset_pre", {31'd0, cpu_reset}, 32'd1);
    check_eq("t8_ram_data_pre",  {14'd0, ram_data}, 32'h01122);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t8_rx_ready",  {31'd0, rx_ready},   32'd0);
    check_eq("t8_cpu_reset", {31'd0, cpu_reset},  32'd0);
    check_eq("t8_busy",      {31'd0, load_busy},  32'd0);
    check_eq("t8_err_code",  {30'd0, err_code},   32'd0);
    check_eq("t8_ram_data",  {14'd0, ram_data},   32'd0);
    check_eq("t8_ram_addr",  {22'd0, ram_address}, 32'd0);
    check_eq("t8_ram_we",    {31'd0, ram_wr_en},  32'd0);
    check_eq("t8_pulses",    {30'd0, load_done, load_error}, 32'd0);
    tick(2);
    @(negedge clk) rst_n = 1'b1;
    tick(1);
    check_eq("t8_ready_again", {31'd0, rx_ready}, 32'd1);
    d0 = done_cnt;
    fr = '{8'hA5, 8'h00, 8'h00, 8'h01, 8'h02, 8'h03, 8'h06};
    send_frame(fr, 0);
    tick(3);
    check_eq("t8_reload_done", done_cnt - d0, 32'd1);
    check_eq("t8_reload_word", {14'd0, ram_model[0]}, 32'h10203);
    check_eq("t8_reload_cpu",  {31'd0, cpu_reset}, 32'd0);

    // invariants watched over the whole run
    check_eq("en_eq_wr_en",     en_mis, 32'd0);
    check_eq("cpu_reset_drops", drop_cnt, 32'd0);
    check_eq("busy_at_pulse",   busy_pulse, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, got cycle %0d, expected < 100000", cyc);
    $fatal(1);
  end

endmodule

// File: doc/picocode_loader.md
# picocode_loader

Streams a program image from a byte source (UART RX or host FIFO) into the 1K x 18 picocode instruction RAM. It frames and validates the image, assembles 18-bit instructions from byte triplets, and drives the RAM write port (data, address, enable, write-enable). It holds the CPU in reset while a load is in progress and releases it only after an image passes its checksum.

## Interface
- TIMEOUT_CYCLES, 1000000: maximum idle cycles between accepted bytes while a load is active; range 2..2^24-1.
- clk  in  1  system clock; all logic rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  loader can accept a byte; transfer happens when rx_valid && rx_ready at a rising edge.
- ram_data  out  18  instruction word to RAM data_in.
- ram_address  out  10  RAM word address.
- ram_enable  out  1  RAM enable; high only during write cycles.
- ram_wr_en  out  1  RAM write enable; equals ram_enable.
- cpu_reset  out  1  active-high hold for the CPU.
- load_busy  out  1  a frame is in progress (any state except IDLE).
- load_done  out  1  one-cycle pulse: image accepted.
- load_error  out  1  one-cycle pulse: frame aborted.
- err_code  out  2  cause of the last error, held until the next error or reset: 01 format, 10 checksum, 11 timeout; 00 means no error since reset.

## Operation
- Frame format, in order:
  - SYNC byte 0xA5.
  - CNT_HI: bits[1:0] = (N-1)[9:8]; bits[7:2] must be 0.
  - CNT_LO: (N-1)[7:0].
  - N words of 3 bytes each: B0 (bits[1:0] = word[17:16], bits[7:2] must be 0), B1 = word[15:8], B2 = word[7:0].
  - CKSUM byte.
- Word count N ranges 1..1024. Word k is written to address k, with k from 0 to N-1. No wrap is possible.
- Checksum: the 8-bit modulo-256 sum of CNT_HI, CNT_LO and all payload bytes, excluding SYNC and CKSUM. The CKSUM byte must equal this sum.
- FSM states: IDLE, CNT_HI, CNT_LO, B0, B1, B2, WRITE, CKSUM.
  - IDLE: any byte other than 0xA5 is consumed and ignored. 0xA5 moves to CNT_HI, sets cpu_reset=1, and clears the sum and word index.
  - CNT_HI → CNT_LO → B0 → B1 → B2 → WRITE.
  - WRITE → B0 if words remain, otherwise → CKSUM.
  - CKSUM → IDLE, with either load_done or load_error.
- Format error: nonzero bits[7:2] in CNT_HI or in any B0.
  - Abort to IDLE, pulse load_error, set err_code=01.
  - Words already written stay in RAM.
- Checksum error: CKSUM mismatch → load_error, err_code=10.
- Timeout: the idle counter resets on every accepted byte and is cleared in IDLE. If it reaches TIMEOUT_CYCLES in any non-IDLE state → load_error, err_code=11, return to IDLE.
- cpu_reset:
  - Set on SYNC acceptance.
  - Cleared only together with load_done.
  - Remains 1 after any error until a later successful load.
- rx_ready is 1 in every state except WRITE.

## Timing
- Reset values: rx_ready=0, ram_data=0, ram_address=0, ram_enable=0, ram_wr_en=0, cpu_reset=0, load_busy=0, load_done=0, load_error=0, err_code=00. The state is IDLE.
- rx_ready is first 1 in the cycle after rst_n deasserts.
- Write: in the cycle after B2 is accepted (the WRITE state), ram_enable=ram_wr_en=1 for exactly one cycle, with ram_address=k and ram_data=word. ram_address and ram_data hold their values afterwards.
- Minimum frame duration: 3 + 4N + 1 cycles (one byte per cycle, plus the WRITE bubble per word).
- load_done / load_error pulse in the cycle after the deciding byte is accepted, or in the cycle after the timeout count is reached.
  - cpu_reset falls in the same cycle as load_done.
  - load_busy falls in the same cycle as either pulse.
- In a given cycle, a byte acceptance takes precedence over a timeout expiry.
- rst_n asserted mid-frame:
  - All outputs return to reset values immediately (asynchronously), including cpu_reset=0.
  - The partial image stays in RAM.

## Test plan
- 2-word load: A5 00 01 01 23 45 03 FF FF 6B at one byte per cycle → writes 0x12345 at address 0 and 0x3FFFF at address 1, each as a single-cycle ram_wr_en. load_done fires one cycle after 6B. cpu_reset is high from the SYNC acceptance through the done cycle.
- Same frame with CKSUM 0x6C → both writes occur, load_error fires, err_code=10, cpu_reset stays 1. Re-sending the correct frame → load_done and cpu_reset=0.
- Garbage 00 FF 5A before A5 00 00 00 00 07 07 → the garbage is ignored, address 0 receives 0x00007, load_done fires.
- Format error: A5 00 00 04 … → load_error one cycle after the 04 byte, err_code=01, no RAM write.
- Timeout with TIMEOUT_CYCLES=16: A5 00 then silence → load_error exactly 16 cycles after the last acceptance, err_code=11. With rx_valid gaps of 15 cycles → no timeout.
- Full 1024-word load with random data and random rx_valid gaps → all 1024 addresses match a RAM model, the last write is at address 0x3FF, load_done fires. Also assert rst_n mid-word and check reset values, then a clean reload succeeds.
